// File: rtl/arcade_input_mapper_pkg.sv
// Shared scancodes, joystick bit positions and coin shaper states for arcade_input_mapper.
package arcade_input_pkg;

  localparam logic [7:0] KEY_UP      = 8'h75;
  localparam logic [7:0] KEY_DOWN    = 8'h72;
  localparam logic [7:0] KEY_LEFT    = 8'h6B;
  localparam logic [7:0] KEY_RIGHT   = 8'h74;
  localparam logic [7:0] KEY_BTN0    = 8'h14;
  localparam logic [7:0] KEY_BTN1    = 8'h11;
  localparam logic [7:0] KEY_BTN2    = 8'h29;
  localparam logic [7:0] KEY_BTN3    = 8'h12;
  localparam logic [7:0] KEY_BTN4    = 8'h1A;
  localparam logic [7:0] KEY_BTN5    = 8'h22;
  localparam logic [7:0] KEY_START0  = 8'h16;
  localparam logic [7:0] KEY_START1  = 8'h1E;
  localparam logic [7:0] KEY_COIN0   = 8'h2E;
  localparam logic [7:0] KEY_COIN1   = 8'h36;
  localparam logic [7:0] KEY_SERVICE = 8'h46;

  localparam int KEY_NUM_BTN = 6;

  localparam int JOY_RIGHT = 0;
  localparam int JOY_LEFT  = 1;
  localparam int JOY_DOWN  = 2;
  localparam int JOY_UP    = 3;
  localparam int JOY_BTN0  = 4;

  typedef enum logic [1:0] {
    CS_IDLE,
    CS_PULSE,
    CS_HOLD
  } coin_state_t;

  function automatic logic [7:0] btn_code(input int k);
    case (k)
      0:       return KEY_BTN0;
      1:       return KEY_BTN1;
      2:       return KEY_BTN2;
      3:       return KEY_BTN3;
      4:       return KEY_BTN4;
      default: return KEY_BTN5;
    endcase
  endfunction

  function automatic logic [7:0] start_code(input int p);
    return (p == 0) ? KEY_START0 : KEY_START1;
  endfunction

  function automatic logic [7:0] coin_code(input int p);
    return (p == 0) ? KEY_COIN0 : KEY_COIN1;
  endfunction

endpackage

// File: rtl/arcade_input_mapper_if.sv
// hps_io side inputs and active-low game core controls; AUTOFIRE_EN adds autofire_mask.
interface arcade_input_mapper_if #(
  parameter int NUM_PLAYERS = 2,
  parameter int NUM_BUTTONS = 3
);
  logic [10:0]                        ps2_key;
  logic [16*NUM_PLAYERS-1:0]          joystick;
  logic [NUM_BUTTONS-1:0]             swap_mask;
`ifdef AUTOFIRE_EN
  logic [NUM_BUTTONS-1:0]             autofire_mask;
`endif
  logic [4*NUM_PLAYERS-1:0]           joy_n;
  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_n;
  logic [NUM_PLAYERS-1:0]             start_n;
  logic [NUM_PLAYERS-1:0]             coin_n;
  logic                               service_n;
  logic                               pause_req;

`ifdef AUTOFIRE_EN
  modport master (
    output ps2_key, joystick, swap_mask, autofire_mask,
    input  joy_n, btn_n, start_n, coin_n, service_n, pause_req
  );
  modport slave (
    input  ps2_key, joystick, swap_mask, autofire_mask,
    output joy_n, btn_n, start_n, coin_n, service_n, pause_req
  );
`else
  modport master (
    output ps2_key, joystick, swap_mask,
    input  joy_n, btn_n, start_n, coin_n, service_n, pause_req
  );
  modport slave (
    input  ps2_key, joystick, swap_mask,
    output joy_n, btn_n, start_n, coin_n, service_n, pause_req
  );
`endif
endinterface

// File: rtl/arcade_coin_shaper.sv
// One coin pulse of exactly COIN_PULSE cycles per press; further presses wait for release.
module arcade_coin_shaper
  import arcade_input_pkg::*;
#(
  parameter logic [15:0] COIN_PULSE = 16'd4096
) (
  input  logic clk_sys,
  input  logic reset,
  input  logic coin_raw,
  output logic coin_n
);

  coin_state_t state;
  logic [15:0] cnt;

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      state  <= CS_IDLE;
      cnt    <= '0;
      coin_n <= 1'b1;
    end else begin
      case (state)
        CS_IDLE: begin
          if (coin_raw) begin
            state  <= CS_PULSE;
            cnt    <= COIN_PULSE - 16'd1;
            coin_n <= 1'b0;
          end
        end
        CS_PULSE: begin
          // Raw coin is ignored here, so a re-press cannot stretch the pulse.
          if (cnt == 16'd0) begin
            coin_n <= 1'b1;
            state  <= coin_raw ? CS_HOLD : CS_IDLE;
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        CS_HOLD: begin
          if (!coin_raw) state <= CS_IDLE;
        end
        default: state <= CS_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/arcade_input_mapper.sv
// Latches ps2 key events, merges them with hps_io joysticks, swaps buttons, shapes coins.
// AUTOFIRE_EN adds autofire_mask/AUTOFIRE_DIV: masked held buttons follow a square wave.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NUM_PLAYERS = 2,
  parameter int          NUM_BUTTONS = 3,
  parameter int          START_BIT   = 7,
  parameter int          COIN_BIT    = 8,
  parameter int          PAUSE_BIT   = 10,
  parameter logic [15:0] COIN_PULSE  = 16'd4096,
  parameter int          KBD_SHARED  = 1
`ifdef AUTOFIRE_EN
  , parameter logic [23:0] AUTOFIRE_DIV = 24'd1638400
`endif
) (
  input logic                  clk_sys,
  input logic                  reset,
  arcade_input_mapper_if.slave bus
);

  logic [10:0] ps2;
  assign ps2 = bus.ps2_key;

  logic                   old_toggle;
  logic                   key_up, key_down, key_left, key_right, key_service;
  logic [NUM_BUTTONS-1:0] key_btn;
  logic [NUM_PLAYERS-1:0] key_start, key_coin;

  // Extended-key flag and spare joystick bits carry nothing for the core.
  logic unused_bits;
  assign unused_bits = ^{ps2[8], bus.joystick};

  function automatic logic kb_on(input int p);
    return (KBD_SHARED != 0) || (p == 0);
  endfunction

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      old_toggle  <= ps2[10];
      key_up      <= 1'b0;
      key_down    <= 1'b0;
      key_left    <= 1'b0;
      key_right   <= 1'b0;
      key_service <= 1'b0;
      key_btn     <= '0;
      key_start   <= '0;
      key_coin    <= '0;
    end else begin
      old_toggle <= ps2[10];
      if (old_toggle != ps2[10]) begin
        if (ps2[7:0] == KEY_UP)      key_up      <= ps2[9];
        if (ps2[7:0] == KEY_DOWN)    key_down    <= ps2[9];
        if (ps2[7:0] == KEY_LEFT)    key_left    <= ps2[9];
        if (ps2[7:0] == KEY_RIGHT)   key_right   <= ps2[9];
        if (ps2[7:0] == KEY_SERVICE) key_service <= ps2[9];
        for (int k = 0; k < NUM_BUTTONS; k++)
          if (k < KEY_NUM_BTN && ps2[7:0] == btn_code(k)) key_btn[k] <= ps2[9];
        for (int p = 0; p < NUM_PLAYERS; p++) begin
          if (p < 2 && ps2[7:0] == start_code(p)) key_start[p] <= ps2[9];
          if (p < 2 && ps2[7:0] == coin_code(p))  key_coin[p]  <= ps2[9];
        end
      end
    end
  end

  logic [4*NUM_PLAYERS-1:0]           joy_d;
  logic [NUM_BUTTONS*NUM_PLAYERS-1:0] btn_d, btn_s, btn_f;
  logic [NUM_PLAYERS-1:0]             start_d, coin_raw, coin_n_q;
  logic                               pause_d;

  always_comb begin
    joy_d    = '0;
    btn_d    = '0;
    start_d  = '0;
    coin_raw = '0;
    pause_d  = 1'b0;
    for (int p = 0; p < NUM_PLAYERS; p++) begin
      joy_d[4*p+0] = bus.joystick[16*p+JOY_LEFT]  | (kb_on(p) & key_left);
      joy_d[4*p+1] = bus.joystick[16*p+JOY_RIGHT] | (kb_on(p) & key_right);
      joy_d[4*p+2] = bus.joystick[16*p+JOY_UP]    | (kb_on(p) & key_up);
      joy_d[4*p+3] = bus.joystick[16*p+JOY_DOWN]  | (kb_on(p) & key_down);
      for (int k = 0; k < NUM_BUTTONS; k++)
        btn_d[NUM_BUTTONS*p+k] = bus.joystick[16*p+JOY_BTN0+k] | (kb_on(p) & key_btn[k]);
      start_d[p]  = bus.joystick[16*p+START_BIT] | (kb_on(p) & key_start[p]);
      coin_raw[p] = bus.joystick[16*p+COIN_BIT]  | (kb_on(p) & key_coin[p]);
      pause_d     = pause_d | bus.joystick[16*p+PAUSE_BIT];
    end
  end

  generate
    if (NUM_PLAYERS >= 2) begin : g_swap
      always_comb begin
        btn_s = btn_d;
        for (int k = 0; k < NUM_BUTTONS; k++) begin
          if (bus.swap_mask[k]) begin
            btn_s[k]             = btn_d[NUM_BUTTONS+k];
            btn_s[NUM_BUTTONS+k] = btn_d[k];
          end
        end
      end
    end else begin : g_noswap
      logic unused_swap;
      assign unused_swap = ^bus.swap_mask;
      assign btn_s       = btn_d;
    end
  endgenerate

`ifdef AUTOFIRE_EN
  logic [23:0] af_cnt;
  logic        af_phase;

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      af_cnt   <= '0;
      af_phase <= 1'b0;
    end else if (af_cnt == AUTOFIRE_DIV - 24'd1) begin
      af_cnt   <= '0;
      af_phase <= ~af_phase;
    end else begin
      af_cnt <= af_cnt + 24'd1;
    end
  end

  always_comb begin
    btn_f = btn_s;
    for (int p = 0; p < NUM_PLAYERS; p++)
      for (int k = 0; k < NUM_BUTTONS; k++)
        if (bus.autofire_mask[k])
          btn_f[NUM_BUTTONS*p+k] = btn_s[NUM_BUTTONS*p+k] & af_phase;
  end
`else
  assign btn_f = btn_s;
`endif

  always_ff @(posedge clk_sys) begin
    if (!reset) begin
      bus.joy_n     <= '1;
      bus.btn_n     <= '1;
      bus.start_n   <= '1;
      bus.service_n <= 1'b1;
      bus.pause_req <= 1'b0;
    end else begin
      bus.joy_n     <= ~joy_d;
      bus.btn_n     <= ~btn_f;
      bus.start_n   <= ~start_d;
      bus.service_n <= ~key_service;
      bus.pause_req <= pause_d;
    end
  end

  for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_coin
    arcade_coin_shaper #(
      .COIN_PULSE(COIN_PULSE)
    ) u_coin (
      .clk_sys (clk_sys),
      .reset   (reset),
      .coin_raw(coin_raw[p]),
      .coin_n  (coin_n_q[p])
    );
  end

  assign bus.coin_n = coin_n_q;

endmodule

// File: tb/tb_arcade_input_mapper.sv
// Random and directed stimulus for arcade_input_mapper against a scancode-indexed key model.
module tb_arcade_input_mapper;

  localparam int NP = 2;
  localparam int NB = 3;
  localparam int KS = 1;
  localparam int CP = 8;

  logic clk_sys = 1'b0;
  logic reset   = 1'b0;
  always #5 clk_sys = ~clk_sys;

  arcade_input_mapper_if #(.NUM_PLAYERS(NP), .NUM_BUTTONS(NB)) bus ();

  arcade_input_mapper #(
    .NUM_PLAYERS(NP),
    .NUM_BUTTONS(NB),
    .COIN_PULSE (16'd8),
    .KBD_SHARED (KS)
`ifdef AUTOFIRE_EN
    , .AUTOFIRE_DIV(24'd4)
`endif
  ) dut (
    .clk_sys(clk_sys),
    .reset  (reset),
    .bus    (bus.slave)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  // Reference: one bit per scancode, outputs recomputed from the rules every cycle.
  bit              keys [0:255];
  bit              old_t;
  logic [4*NP-1:0] e_joy_n;
  logic [NB*NP-1:0] e_btn_n;
  logic [NP-1:0]   e_start_n, e_coin_n;
  logic            e_service_n, e_pause;
  int              coin_left [NP];
  bit              coin_wait [NP];
  logic [7:0]      btn_codes [6]  = '{8'h14, 8'h11, 8'h29, 8'h12, 8'h1A, 8'h22};
  logic [7:0]      start_codes [2] = '{8'h16, 8'h1E};
  logic [7:0]      coin_codes [2]  = '{8'h2E, 8'h36};
  logic [7:0]      all_codes [15]  = '{8'h75, 8'h72, 8'h6B, 8'h74, 8'h14, 8'h11, 8'h29, 8'h12,
                                       8'h1A, 8'h22, 8'h16, 8'h1E, 8'h2E, 8'h36, 8'h46};

  task automatic model_step();
    bit b [NP][NB];
    bit t, kb, raw;
    logic [31:0] j;
    j = 32'(bus.joystick);
    if (!reset) begin
      foreach (keys[i]) keys[i] = 1'b0;
      old_t       = bus.ps2_key[10];
      e_joy_n     = '1;
      e_btn_n     = '1;
      e_start_n   = '1;
      e_coin_n    = '1;
      e_service_n = 1'b1;
      e_pause     = 1'b0;
      for (int p = 0; p < NP; p++) begin
        coin_left[p] = 0;
        coin_wait[p] = 1'b0;
      end
    end else begin
      e_pause = 1'b0;
      for (int p = 0; p < NP; p++) begin
        kb = (KS != 0) || (p == 0);
        e_joy_n[4*p+0] = ~(j[16*p+1] | (kb & keys[8'h6B]));
        e_joy_n[4*p+1] = ~(j[16*p+0] | (kb & keys[8'h74]));
        e_joy_n[4*p+2] = ~(j[16*p+3] | (kb & keys[8'h75]));
        e_joy_n[4*p+3] = ~(j[16*p+2] | (kb & keys[8'h72]));
        for (int k = 0; k < NB; k++) b[p][k] = j[16*p+4+k] | (kb & keys[btn_codes[k]]);
        e_start_n[p] = ~(j[16*p+7] | (kb & (p < 2) & keys[start_codes[p]]));
        e_pause      = e_pause | j[16*p+10];
        raw          = j[16*p+8] | (kb & (p < 2) & keys[coin_codes[p]]);
        if (coin_left[p] > 0) begin
          coin_left[p]--;
          if (coin_left[p] == 0) begin
            e_coin_n[p]  = 1'b1;
            coin_wait[p] = raw;
          end
        end else if (coin_wait[p]) begin
          coin_wait[p] = raw;
        end else if (raw) begin
          coin_left[p] = CP;
          e_coin_n[p]  = 1'b0;
        end
      end
      for (int k = 0; k < NB; k++) begin
        if (NP >= 2 && bus.swap_mask[k]) begin
          t = b[0][k]; b[0][k] = b[1][k]; b[1][k] = t;
        end
      end
      for (int p = 0; p < NP; p++)
        for (int k = 0; k < NB; k++) e_btn_n[NB*p+k] = ~b[p][k];
      e_service_n = ~keys[8'h46];
      if (old_t != bus.ps2_key[10]) keys[bus.ps2_key[7:0]] = bus.ps2_key[9];
      old_t = bus.ps2_key[10];
    end
  endtask

  task automatic step(input bit cmp);
    @(posedge clk_sys);
    model_step();
    @(negedge clk_sys);
    if (cmp) begin
      chk("joy_n",     32'(bus.joy_n),     32'(e_joy_n));
      chk("btn_n",     32'(bus.btn_n),     32'(e_btn_n));
      chk("start_n",   32'(bus.start_n),   32'(e_start_n));
      chk("coin_n",    32'(bus.coin_n),    32'(e_coin_n));
      chk("service_n", 32'(bus.service_n), 32'(e_service_n));
      chk("pause_req", 32'(bus.pause_req), 32'(e_pause));
    end
  endtask

  task automatic key_evt(input logic [7:0] code, input logic pr, input logic ext);
    bus.ps2_key = {~bus.ps2_key[10], pr, ext, code};
  endtask

  int          lows, falls;
  logic        prev_c;
  logic [31:0] jr;
  logic [7:0]  code;
  logic        af_s [20];
  logic        af_u [20];

  initial begin
    bus.ps2_key   = 11'h400;
    bus.joystick  = '0;
    bus.swap_mask = '0;
`ifdef AUTOFIRE_EN
    bus.autofire_mask = '0;
`endif
    reset = 1'b0;
    repeat (4) step(1);
    chk("rst_btn_n", 32'(bus.btn_n), 32'h3F);
    chk("rst_coin_n", 32'(bus.coin_n), 32'h3);
    reset = 1'b1;
    repeat (3) step(1);
    chk("rel_no_key", 32'(bus.btn_n), 32'h3F);
    chk("rel_pause", 32'(bus.pause_req), 32'h0);

    key_evt(8'h14, 1'b1, 1'b0);
    step(1);
    chk("kbd_lat1", 32'(bus.btn_n), 32'h3F);
    step(1);
    chk("kbd_p0b0", 32'(bus.btn_n[0]), 32'h0);
    chk("kbd_p1b0", 32'(bus.btn_n[3]), 32'h0);
    key_evt(8'h14, 1'b0, 1'b0);
    repeat (2) step(1);
    chk("kbd_rel", 32'(bus.btn_n), 32'h3F);

    bus.joystick  = 32'h1 << 22;
    bus.swap_mask = 3'b100;
    step(1);
    chk("swap_p0b2", 32'(bus.btn_n[2]), 32'h0);
    chk("swap_p1b2", 32'(bus.btn_n[5]), 32'h1);
    bus.joystick  = '0;
    bus.swap_mask = '0;
    repeat (2) step(1);

    bus.joystick = 32'h100;
    lows = 0; falls = 0; prev_c = 1'b1;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (!bus.coin_n[0]) lows++;
      if (prev_c && !bus.coin_n[0]) falls++;
      prev_c = bus.coin_n[0];
    end
    chk("coin_hold_low", 32'(lows), 32'd8);
    chk("coin_hold_pulses", 32'(falls), 32'd1);
    bus.joystick = '0;
    repeat (3) step(1);

    lows = 0;
    bus.joystick = 32'h100;
    step(1); if (!bus.coin_n[0]) lows++;
    bus.joystick = '0;
    for (int i = 0; i < 12; i++) begin step(1); if (!bus.coin_n[0]) lows++; end
    chk("coin_short_low", 32'(lows), 32'd8);

    lows = 0;
    bus.joystick = 32'h100;
    step(1); if (!bus.coin_n[0]) lows++;
    bus.joystick = '0;
    for (int i = 0; i < 2; i++) begin step(1); if (!bus.coin_n[0]) lows++; end
    bus.joystick = 32'h100;
    for (int i = 0; i < 2; i++) begin step(1); if (!bus.coin_n[0]) lows++; end
    bus.joystick = '0;
    for (int i = 0; i < 10; i++) begin step(1); if (!bus.coin_n[0]) lows++; end
    chk("coin_repress_low", 32'(lows), 32'd8);

    bus.joystick = 32'h100;
    repeat (3) step(1);
    reset = 1'b0;
    step(1);
    chk("coin_rst_mid", 32'(bus.coin_n[0]), 32'h1);
    reset = 1'b1;
    lows = 0;
    for (int i = 0; i < 12; i++) begin step(1); if (!bus.coin_n[0]) lows++; end
    chk("coin_after_rst", 32'(lows), 32'd8);
    bus.joystick = '0;
    repeat (2) step(1);

    for (int i = 0; i < 1500; i++) begin
      reset = ($urandom_range(0, 99) != 0);
      if ($urandom_range(0, 3) == 0) begin
        jr = $urandom & 32'hFEFF_FEFF;
        if ($urandom_range(0, 5) == 0) jr[8]  = 1'b1;
        if ($urandom_range(0, 5) == 0) jr[24] = 1'b1;
        bus.joystick = jr;
      end
      if ($urandom_range(0, 4) == 0) begin
        code = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(0, 255))
                                           : all_codes[$urandom_range(0, 14)];
        key_evt(code, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      end
      if ($urandom_range(0, 15) == 0) bus.swap_mask = 3'($urandom_range(0, 7));
      step(1);
    end

`ifdef AUTOFIRE_EN
    reset             = 1'b1;
    bus.swap_mask     = '0;
    bus.joystick      = 32'h30;
    bus.autofire_mask = 3'b001;
    repeat (2) step(0);
    for (int i = 0; i < 20; i++) begin
      step(0);
      af_s[i] = bus.btn_n[0];
      af_u[i] = bus.btn_n[1];
    end
    for (int i = 4; i < 20; i++) begin
      chk("af_toggle", 32'(af_s[i]), 32'(~af_s[i-4]));
      chk("af_unmasked", 32'(af_u[i]), 32'h0);
    end
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/arcade_input_mapper.md
Name: arcade_input_mapper

Overview:
Parametrised replacement for the hand-written keyboard/joystick glue in per-game emu tops. Decodes ps2_key events into latched key states and merges them with N hps_io joysticks. Applies per-button cross-player swap (regional variants) and coin pulse shaping. Drives active-low registered controls straight into a game core.

Parameters:
NUM_PLAYERS, 2, players/joysticks handled (1..4)
NUM_BUTTONS, 3, fire buttons per player (1..8)
START_BIT, 7, joystick bit carrying Start
COIN_BIT, 8, joystick bit carrying Coin
PAUSE_BIT, 10, joystick bit carrying Pause (OR of all players)
COIN_PULSE, 16'd4096, coin output low-time in clk_sys cycles (>=1)
KBD_SHARED, 1, 1: keyboard drives every player; 0: player 0 only

Ports:
clk_sys  in  1  system clock
reset  in  1  synchronous, active-low reset
ps2_key  in  11  hps_io key event: [10] toggle, [9] pressed, [7:0] scancode
joystick  in  16*NUM_PLAYERS  player p at [16p+15:16p]; [0]R [1]L [2]D [3]U [4+k] button k
swap_mask  in  NUM_BUTTONS  bit k set: button k of players 0/1 exchanged (ignored if NUM_PLAYERS<2)
joy_n  out  4*NUM_PLAYERS  per player {D,U,R,L}, active-low
btn_n  out  NUM_BUTTONS*NUM_PLAYERS  per player buttons, active-low
start_n  out  NUM_PLAYERS  active-low
coin_n  out  NUM_PLAYERS  shaped coin, active-low
service_n  out  1  active-low
pause_req  out  1  active-high

Behaviour:
- Reset (reset==0 at clk edge): all *_n outputs 1, pause_req 0, key latches 0, coin counters 0, coin armed 1; old_toggle <= ps2_key[10] (no spurious event on release).
- Key event: old_toggle != ps2_key[10] → latch[code] <= ps2_key[9]; old_toggle updated every cycle. Map: 0x75 U, 0x72 D, 0x6B L, 0x74 R, 0x14 btn0, 0x11 btn1, 0x29 btn2, 0x12 btn3, 0x1A btn4, 0x22 btn5 (buttons >= NUM_BUTTONS ignored); 0x16 start0, 0x1E start1, 0x2E coin0, 0x36 coin1, 0x46 service. Unmapped codes ignored. Extended bit [8] ignored.
- Merge (combinational, then one output register): ctl_p = joystick_p bits | (KBD_SHARED || p==0 ? key latches : 0). Start/coin keys apply only to their own player index.
- Swap: after merge, for k with swap_mask[k]: btn0[k]<->btn1[k]. Directions, start, coin never swapped.
- Latency: joystick/swap change → output 1 cycle; key event → output 2 cycles (latch, register).
- pause_req = OR over p of joystick_p[PAUSE_BIT], registered.
- Coin shaper per player, states IDLE/PULSE/HOLD: IDLE & raw coin=1 → PULSE, cnt<=COIN_PULSE-1, coin_n<=0. PULSE: cnt decrements; at cnt==0 → coin_n<=1, HOLD if raw still 1 else IDLE. HOLD → IDLE when raw=0. Exactly one pulse of COIN_PULSE cycles per press regardless of press length; a press shorter than COIN_PULSE still yields a full pulse; re-press during PULSE ignored.
- Opposing directions passed through unchanged (core decides).

Optional Feature:
AUTOFIRE_EN: adds input autofire_mask [NUM_BUTTONS] and parameter AUTOFIRE_DIV (default 24'd1638400, ~15 Hz half-period at 49.152 MHz). Free-running divider toggles af_phase every AUTOFIRE_DIV cycles (reset: 0 / phase 0). Held button k with mask bit set outputs btn & af_phase (active-high before inversion), applied after swap. Without macro: port/parameter absent, buttons pass straight.

Decomposition:
Package arcade_input_pkg: scancode localparams (KEY_UP ... KEY_SERVICE), joystick bit index constants, coin state enum. Sub-module arcade_coin_shaper (one instance per player, params COIN_PULSE); rest flat.

Test Plan:
- Reset held with ps2_key[10]=1, then released → no key latched, all *_n=1, pause_req=0.
- Toggle ps2_key[10] with 0x14 pressed (KBD_SHARED=1) → btn_n bit 0 of both players 0 on 2nd cycle; release event → back to 1 after 2 cycles.
- joystick[1*16+6]=1, swap_mask=3'b100 → player0 btn2_n=0, player1 btn2_n=1, one cycle later.
- COIN_PULSE=8: coin held 100 cycles → coin_n low exactly 8 cycles, one pulse; then 1-cycle press → another 8-cycle pulse; press during pulse → no extension.
- Reset asserted mid-pulse → coin_n=1 next cycle, state IDLE; held coin after reset → new pulse.
- AUTOFIRE_EN, AUTOFIRE_DIV=4, mask bit0 set, button held → btn_n[0] toggles every 4 cycles; unmasked button steady low.
